elf_mem_ctrl: RTL and testbench
===============================

ELF_MEM_CTRL -- requirements
Module: elf_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, 12, RAM address width; RAM depth is 2^ADDR_W bytes.
REQ-002 Parameter NUM_IMG, 2, number of valid ioctl image indices.
REQ-003 Parameter IMG_STRIDE, 12'h400, base offset per ioctl index (image i loads at i*IMG_STRIDE).
REQ-004 Parameter WR_LO, 12'h800, inclusive lower bound of CPU-writable window.
REQ-005 Parameter WR_HI, 12'hA00, exclusive upper bound of CPU-writable window.
REQ-006 Parameter CLEAR_EN, 1, zero-fill all RAM after reset when 1.
REQ-007 Parameter HOLD_CYC, 16, cycles CPU reset is held after a download ends (>=1).
REQ-008 clk  in  1  system clock; all logic on rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 ioctl_download  in  1  download in progress.
REQ-011 ioctl_index  in  8  image index.
REQ-012 ioctl_wr  in  1  download byte strobe, one cycle per byte.
REQ-013 ioctl_addr  in  25  byte offset within image.
REQ-014 ioctl_dout  in  8  download byte.
REQ-015 cpu_addr  in  16  CPU address.
REQ-016 cpu_wr  in  1  CPU write strobe.
REQ-017 cpu_dout  in  8  CPU write data.
REQ-018 ram_addr  out  ADDR_W  RAM port A address.
REQ-019 ram_din  out  8  RAM port A write data.
REQ-020 ram_wren  out  1  RAM port A write enable.
REQ-021 cpu_reset  out  1  CPU clear request.
REQ-022 load_done  out  1  one-cycle pulse when HOLD completes after a download.
REQ-023 load_err  out  1  sticky: write attempted with ioctl_index >= NUM_IMG.
REQ-024 load_count  out  ADDR_W+1  bytes accepted in the current/last download.

Function
REQ-025 States CLEAR, RUN, LOAD, HOLD; one state register.
REQ-026 CLEAR: ram_addr = clear counter, ram_din = 0, ram_wren = 1; counter steps 0..2^ADDR_W-1, then RUN; each address written exactly once.
REQ-027 CLEAR is not interrupted by ioctl_download; a download asserted during CLEAR is entered on the cycle after the final clear write.
REQ-028 RUN: ram_addr = cpu_addr[ADDR_W-1:0]; ram_din = cpu_dout; ram_wren = cpu_wr and WR_LO <= cpu_addr[ADDR_W-1:0] < WR_HI.
REQ-029 RUN -> LOAD when ioctl_download = 1; load_count cleared to 0 on entry.
REQ-030 LOAD: ram_addr = (ioctl_addr[ADDR_W-1:0] + ioctl_index*IMG_STRIDE) mod 2^ADDR_W; ram_din = ioctl_dout; ram_wren = ioctl_wr and ioctl_index < NUM_IMG.
REQ-031 LOAD: CPU writes ignored; load_count increments per accepted byte, saturating at 2^ADDR_W.
REQ-032 ioctl_wr with ioctl_index >= NUM_IMG: no RAM write, load_err set, load_count unchanged.
REQ-033 LOAD -> HOLD when ioctl_download = 0; hold counter loaded with HOLD_CYC-1.
REQ-034 HOLD: ram port as RUN but ram_wren = 0; counter decrements; at 0, load_done = 1 for one cycle and -> RUN.
REQ-035 HOLD -> LOAD if ioctl_download reasserts; hold counter abandoned, load_count cleared, no load_done.
REQ-036 cpu_reset = 1 in CLEAR, LOAD, HOLD; 0 in RUN; combinational from state.
REQ-037 ram_addr/ram_din/ram_wren combinational from state and inputs; RAM write takes effect same edge (zero added latency).

Reset
REQ-038 reset synchronous, priority over all transitions; mid-CLEAR/LOAD/HOLD aborts immediately.
REQ-039 After reset: state = CLEAR if CLEAR_EN else RUN; clear counter 0; hold counter 0; load_count 0; load_err 0; load_done 0; cpu_reset 1 during reset cycle.

Verification
REQ-040 Reset with CLEAR_EN=1 -> 4096 consecutive ram_wren cycles, ram_din=0, addresses 0..FFF, then cpu_reset=0.
REQ-041 Download index 1, ioctl_addr 0x000..0x0FF -> writes at 0x400..0x4FF, load_count=256; HOLD_CYC cycles later load_done pulse, cpu_reset falls next cycle.
REQ-042 RUN, cpu_wr at 0x7FF, 0x800, 0x9FF, 0xA00 -> ram_wren only at 0x800 and 0x9FF; cpu_addr 0x1800 -> writes 0x800.
REQ-043 ioctl_wr with index 5 -> no ram_wren, load_err=1 and stays 1 until reset.
REQ-044 ioctl_download reasserted at HOLD count 3 -> LOAD, load_count=0, no load_done; reset mid-LOAD -> CLEAR restarts at address 0.
REQ-045 Index 3, IMG_STRIDE 0x400, ioctl_addr 0x7FF -> wraps to ram_addr 0x3FF.

Source files
------------

// File: rtl/elf_mem_ctrl.sv
// Arbitrates RAM port A between a power-on zero fill, ioctl image downloads and CPU writes,
// and holds the CPU in reset while the RAM contents are being rebuilt.
module elf_mem_ctrl #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned NUM_IMG    = 2,
    parameter int unsigned IMG_STRIDE = 32'h400,
    parameter int unsigned WR_LO      = 32'h800,
    parameter int unsigned WR_HI      = 32'hA00,
    parameter bit          CLEAR_EN   = 1'b1,
    parameter int unsigned HOLD_CYC   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [15:0]       cpu_addr,
    input  logic              cpu_wr,
    input  logic [7:0]        cpu_dout,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_wren,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   load_count
);

    localparam int unsigned     HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYC - 1);
    localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_RUN,
        ST_LOAD,
        ST_HOLD
    } state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   clr_cnt_reg;
    logic [HOLD_W-1:0]   hold_cnt_reg;
    logic [ADDR_W:0]     load_count_reg;
    logic                load_err_reg;

    logic [31:0]         img_base;
    logic [31:0]         cpu_lo;
    logic [ADDR_W-1:0]   load_addr;
    logic                idx_ok;
    logic                cpu_in_window;
    logic                unused_bits;

    // Image base is taken modulo the RAM size, so out-of-range indices simply wrap.
    assign img_base      = 32'(ioctl_index) * IMG_STRIDE;
    assign load_addr     = ioctl_addr[ADDR_W-1:0] + img_base[ADDR_W-1:0];
    assign idx_ok        = 32'(ioctl_index) < NUM_IMG;
    assign cpu_lo        = 32'(cpu_addr[ADDR_W-1:0]);
    assign cpu_in_window = (cpu_lo >= WR_LO) && (cpu_lo < WR_HI);
    assign unused_bits   = ^{ioctl_addr, cpu_addr, img_base};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= CLEAR_EN ? ST_CLEAR : ST_RUN;
            clr_cnt_reg    <= '0;
            hold_cnt_reg   <= '0;
            load_count_reg <= '0;
            load_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    clr_cnt_reg <= clr_cnt_reg + ADDR_W'(1);
                    if (&clr_cnt_reg) begin
                        if (ioctl_download) begin
                            state_reg      <= ST_LOAD;
                            load_count_reg <= '0;
                        end else begin
                            state_reg <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (ioctl_download) begin
                        state_reg      <= ST_LOAD;
                        load_count_reg <= '0;
                    end
                end
                ST_LOAD: begin
                    if (ioctl_wr) begin
                        if (!idx_ok) begin
                            load_err_reg <= 1'b1;
                        end else if (load_count_reg != COUNT_MAX) begin
                            load_count_reg <= load_count_reg + (ADDR_W+1)'(1);
                        end
                    end
                    if (!ioctl_download) begin
                        state_reg    <= ST_HOLD;
                        hold_cnt_reg <= HOLD_INIT;
                    end
                end
                ST_HOLD: begin
                    // A new download restarts loading; the pending release is dropped.
                    if (ioctl_download) begin
                        state_reg      <= ST_LOAD;
                        load_count_reg <= '0;
                    end else if (hold_cnt_reg == '0) begin
                        state_reg <= ST_RUN;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg - HOLD_W'(1);
                    end
                end
                default: state_reg <= ST_RUN;
            endcase
        end
    end

    always_comb begin
        ram_addr = cpu_addr[ADDR_W-1:0];
        ram_din  = cpu_dout;
        ram_wren = 1'b0;
        case (state_reg)
            ST_CLEAR: begin
                ram_addr = clr_cnt_reg;
                ram_din  = 8'h00;
                ram_wren = 1'b1;
            end
            ST_RUN: begin
                ram_wren = cpu_wr && cpu_in_window;
            end
            ST_LOAD: begin
                ram_addr = load_addr;
                ram_din  = ioctl_dout;
                ram_wren = ioctl_wr && idx_ok;
            end
            default: ;
        endcase
    end

    assign cpu_reset  = reset || (state_reg != ST_RUN);
    assign load_done  = !reset && (state_reg == ST_HOLD) && (hold_cnt_reg == '0) && !ioctl_download;
    assign load_err   = load_err_reg;
    assign load_count = load_count_reg;

endmodule

// File: tb/tb_elf_mem_ctrl.sv
// Directed bench for elf_mem_ctrl: per-cycle expectations from a transaction-level model,
// a shadow RAM image, and a few literal pins.
module tb_elf_mem_ctrl;

    localparam int ADDR_W     = 12;
    localparam int DEPTH      = 1 << ADDR_W;
    localparam int NUM_IMG    = 2;
    localparam int IMG_STRIDE = 'h400;
    localparam int HOLD_CYC   = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ioctl_download = 1'b0;
    logic [7:0]        ioctl_index = 8'd0;
    logic              ioctl_wr = 1'b0;
    logic [24:0]       ioctl_addr = 25'd0;
    logic [7:0]        ioctl_dout = 8'd0;
    logic [15:0]       cpu_addr = 16'd0;
    logic              cpu_wr = 1'b0;
    logic [7:0]        cpu_dout = 8'd0;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_din;
    logic              ram_wren;
    logic              cpu_reset;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   load_count;

    always #5 clk = ~clk;

    elf_mem_ctrl #(
        .ADDR_W(ADDR_W), .NUM_IMG(NUM_IMG), .IMG_STRIDE(IMG_STRIDE),
        .WR_LO('h800), .WR_HI('hA00), .CLEAR_EN(1'b1), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk(clk), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_wren(ram_wren),
        .cpu_reset(cpu_reset), .load_done(load_done), .load_err(load_err),
        .load_count(load_count)
    );

    // RAM driven by the DUT's port A, and the image the bench expects it to hold.
    logic [7:0] ram       [DEPTH];
    logic [7:0] model_mem [DEPTH];
    always @(posedge clk) if (ram_wren) ram[ram_addr] <= ram_din;

    int n_vec = 0;
    int n_bad = 0;
    int chk_mode = 0;
    int m_count = 0;
    logic m_err = 1'b0;

    logic              exp_wren = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [7:0]        exp_din = 8'd0;
    logic              exp_cpu_reset = 1'b1;
    logic              exp_done = 1'b0;
    logic [ADDR_W:0]   exp_count = '0;
    logic              exp_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_mode >= 1) chk("cpu_reset", 32'(cpu_reset), 32'(exp_cpu_reset));
        if (chk_mode == 2) begin
            chk("ram_wren",   32'(ram_wren),   32'(exp_wren));
            chk("ram_addr",   32'(ram_addr),   32'(exp_addr));
            chk("ram_din",    32'(ram_din),    32'(exp_din));
            chk("load_done",  32'(load_done),  32'(exp_done));
            chk("load_count", 32'(load_count), 32'(exp_count));
            chk("load_err",   32'(load_err),   32'(exp_err));
        end
    end

    function automatic logic [ADDR_W-1:0] model_addr(input int idx, input int a);
        int s;
        s = (a + idx * IMG_STRIDE) % DEPTH;
        return ADDR_W'(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_status(input logic cpu_rst, input logic done);
        exp_cpu_reset = cpu_rst;
        exp_done      = done;
        exp_count     = (ADDR_W+1)'(m_count);
        exp_err       = m_err;
    endtask

    task automatic apply_reset();
        tick();
        reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; cpu_wr = 1'b0;
        exp_cpu_reset = 1'b1;
        chk_mode = 1;
        m_count = 0;
        m_err = 1'b0;
        $display("txn reset");
    endtask

    // Zero fill; ioctl_download is raised from clear address dl_from onwards.
    task automatic do_clear(input int dl_from);
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            reset = 1'b0;
            ioctl_download = (k >= dl_from);
            ioctl_wr = 1'b0;
            cpu_wr = 1'b1; cpu_addr = 16'h0900; cpu_dout = 8'hEE;
            exp_wren = 1'b1; exp_addr = ADDR_W'(k); exp_din = 8'h00;
            set_status(1'b1, 1'b0);
            model_mem[k] = 8'h00;
            chk_mode = 2;
        end
        $display("txn clear done, download=%0b", ioctl_download);
    endtask

    task automatic run_cycle(input logic [15:0] a, input logic wr, input logic [7:0] d,
                             input logic want_wren);
        tick();
        ioctl_download = 1'b0; ioctl_wr = 1'b0;
        cpu_addr = a; cpu_wr = wr; cpu_dout = d;
        exp_wren = want_wren; exp_addr = ADDR_W'(int'(a) % DEPTH); exp_din = d;
        set_status(1'b0, 1'b0);
        if (want_wren) model_mem[int'(a) % DEPTH] = d;
        $display("txn cpu addr=%h wr=%0b data=%h", a, wr, d);
    endtask

    task automatic load_start();
        tick();
        ioctl_download = 1'b1; ioctl_wr = 1'b0; cpu_wr = 1'b0;
        exp_wren = 1'b0; exp_addr = ADDR_W'(int'(cpu_addr) % DEPTH); exp_din = cpu_dout;
        set_status(1'b0, 1'b0);
        m_count = 0;
        $display("txn download start");
    endtask

    task automatic load_byte(input int idx, input int a, input logic [7:0] d, input logic wr);
        logic ok;
        tick();
        ok = (idx < NUM_IMG);
        ioctl_download = 1'b1; ioctl_index = 8'(idx); ioctl_addr = 25'(a);
        ioctl_dout = d; ioctl_wr = wr;
        cpu_wr = 1'b1; cpu_addr = 16'h0880; cpu_dout = 8'h77;
        exp_wren = wr && ok; exp_addr = model_addr(idx, a); exp_din = d;
        set_status(1'b1, 1'b0);
        if (wr) begin
            if (ok) begin
                model_mem[int'(model_addr(idx, a))] = d;
                if (m_count < DEPTH) m_count++;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic load_end();
        tick();
        ioctl_download = 1'b0; ioctl_wr = 1'b0;
        exp_wren = 1'b0;
        exp_addr = model_addr(int'(ioctl_index), int'(ioctl_addr));
        exp_din = ioctl_dout;
        set_status(1'b1, 1'b0);
        $display("txn download end, %0d bytes accepted", m_count);
    endtask

    // reassert_at < 0: let the hold run to completion.
    task automatic hold_cycles(input int reassert_at);
        int last;
        last = (reassert_at < 0) ? HOLD_CYC - 1 : reassert_at;
        for (int j = 0; j <= last; j++) begin
            tick();
            ioctl_download = (j == reassert_at); ioctl_wr = 1'b0;
            cpu_wr = 1'b1; cpu_addr = 16'h0900; cpu_dout = 8'h99;
            exp_wren = 1'b0; exp_addr = 12'h900; exp_din = 8'h99;
            set_status(1'b1, (reassert_at < 0) && (j == HOLD_CYC - 1));
        end
        if (reassert_at >= 0) m_count = 0;
        $display("txn hold %s after %0d cycles", (reassert_at < 0) ? "complete" : "abandoned", last + 1);
    endtask

    task automatic check_image(input string tag);
        int diffs;
        diffs = 0;
        for (int a = 0; a < DEPTH; a++) if (ram[a] !== model_mem[a]) diffs++;
        chk(tag, 32'(diffs), 32'd0);
        $display("txn image check %s", tag);
    endtask

    initial begin
        apply_reset();
        do_clear(DEPTH);

        // CPU window: only 0x800..0x9FF (low ADDR_W bits) is writable.
        run_cycle(16'h07FF, 1'b1, 8'h10, 1'b0);
        run_cycle(16'h0800, 1'b1, 8'h11, 1'b1);
        run_cycle(16'h09FF, 1'b1, 8'h12, 1'b1);
        run_cycle(16'h0A00, 1'b1, 8'h13, 1'b0);
        run_cycle(16'h1800, 1'b1, 8'h55, 1'b1);
        run_cycle(16'h0123, 1'b1, 8'h14, 1'b0);
        run_cycle(16'h0850, 1'b0, 8'h15, 1'b0);

        // Image 1, 256 bytes.
        load_start();
        for (int i = 0; i < 256; i++) load_byte(1, i, 8'(i) ^ 8'h5A, 1'b1);
        load_end();
        @(negedge clk);
        chk("count_256_lit", 32'(load_count), 32'd256);
        hold_cycles(-1);
        run_cycle(16'h0000, 1'b0, 8'h00, 1'b0);

        // Bad index, a good write, then a restart during hold and a wrapping address.
        load_start();
        load_byte(5, 'h10, 8'hAB, 1'b1);
        load_byte(0, 'h20, 8'hC3, 1'b1);
        load_end();
        hold_cycles(HOLD_CYC - 4);
        load_byte(3, 'h7FF, 8'h3C, 1'b1);
        @(negedge clk);
        chk("wrap_addr_lit", 32'(ram_addr), 32'h3FF);
        load_byte(1, 'h7FF, 8'h6D, 1'b1);
        load_end();
        hold_cycles(-1);
        run_cycle(16'h0900, 1'b1, 8'h42, 1'b1);
        @(negedge clk);
        chk("err_sticky_lit", 32'(load_err), 32'd1);

        tick();
        check_image("image_a");
        chk("ram400_lit", 32'(ram[12'h400]), 32'h5A);
        chk("ram4ff_lit", 32'(ram[12'h4FF]), 32'hA5);
        chk("ram800_lit", 32'(ram[12'h800]), 32'h55);
        chk("ram020_lit", 32'(ram[12'h020]), 32'hC3);
        chk("rambff_lit", 32'(ram[12'hBFF]), 32'h6D);

        // Reset mid-download, then a download raised late in the clear.
        load_start();
        for (int i = 0; i < 3; i++) load_byte(0, 'h100 + i, 8'hF0 + 8'(i), 1'b1);
        apply_reset();
        do_clear(DEPTH - 3);
        for (int i = 0; i < 4; i++) load_byte(1, 'h10 + i, 8'h80 + 8'(i), 1'b1);
        load_end();
        hold_cycles(-1);
        run_cycle(16'h0000, 1'b0, 8'h00, 1'b0);
        tick();
        chk_mode = 0;
        check_image("image_b");
        chk("ram413_lit", 32'(ram[12'h413]), 32'h83);
        chk("ram100_lit", 32'(ram[12'h100]), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
